// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: instruction-fetch front end (PC, imem req/ack, valid/ready handoff to decode).
// Optional FETCH_MISALIGN_TRAP_EN: misaligned next PC faults instead of being force-aligned. Rev 1.0
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  sel_pc,
  input  logic [31:0] jr_target,
  input  logic        halt,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [7:0]  tcnt;
  logic        req_r;
  logic        valid_r;
  logic        fault_r;

  logic [31:0] p4;
  logic [31:0] br_off;
  logic [31:0] next_pc_raw;
  logic [31:0] next_pc;

  always_comb begin
    p4     = pc_r + 32'd4;
    br_off = {{14{instr_r[15]}}, instr_r[15:0], 2'b00};
    case (sel_pc)
      2'b00:   next_pc_raw = p4;
      2'b01:   next_pc_raw = p4 + br_off;
      2'b10:   next_pc_raw = {p4[31:28], instr_r[25:0], 2'b00};
      default: next_pc_raw = jr_target;
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    next_pc = next_pc_raw;
`else
    next_pc = next_pc_raw & 32'hFFFF_FFFC;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pc_r    <= RESET_PC;
      instr_r <= '0;
      tcnt    <= '0;
      req_r   <= 1'b0;
      valid_r <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!halt) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (pc_r[1:0] != 2'b00) begin
              state   <= FAULT;
              fault_r <= 1'b1;
            end else begin
              state <= FETCH;
              req_r <= 1'b1;
            end
`else
            state <= FETCH;
            req_r <= 1'b1;
`endif
          end
        end
        FETCH: begin
          // halt deliberately ignored: an issued request always completes or times out
          if (imem_ack) begin
            instr_r <= imem_rdata;
            tcnt    <= '0;
            req_r   <= 1'b0;
            valid_r <= 1'b1;
            state   <= VALID;
          end else if (tcnt == TMO_LAST) begin
            tcnt    <= '0;
            req_r   <= 1'b0;
            fault_r <= 1'b1;
            state   <= FAULT;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        VALID: begin
          if (instr_ready) begin
            pc_r    <= next_pc;
            valid_r <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (next_pc_raw[1:0] != 2'b00) begin
              fault_r <= 1'b1;
              state   <= FAULT;
            end else if (halt) begin
              state <= IDLE;
            end else begin
              req_r <= 1'b1;
              state <= FETCH;
            end
`else
            if (halt) begin
              state <= IDLE;
            end else begin
              req_r <= 1'b1;
              state <= FETCH;
            end
`endif
          end
        end
        default: begin
          // sticky until reset; late acks land here and are dropped
          req_r   <= 1'b0;
          valid_r <= 1'b0;
          fault_r <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign instr_valid = valid_r;
  assign instr       = instr_r;
  assign opcode      = instr_r[31:26];
  assign funct       = instr_r[5:0];
  assign pc          = pc_r;
  assign pc_plus4    = p4;
  assign fault       = fault_r;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: directed fetch sequence with a request/instruction scoreboard and inline boundary checks.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  sel_pc = 2'b00;
  logic [31:0] jr_target = '0;
  logic        halt = 1'b0;
  logic        fault;

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .opcode(opcode), .funct(funct), .pc(pc), .pc_plus4(pc_plus4),
    .sel_pc(sel_pc), .jr_target(jr_target), .halt(halt), .fault(fault)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // scoreboard queues
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_pc_q[$];

  logic        prev_req = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] m_addr, m_data, m_pc;

  always @(negedge clock) begin
    if (reset_n) begin
      if (imem_req && !prev_req) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_req: got request at %h, required none", imem_addr);
        end else begin
          m_addr = exp_addr_q.pop_front();
          chk("req_addr", imem_addr, m_addr);
        end
      end
      if (instr_valid && !prev_valid) begin
        if (exp_data_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_valid: got instr %h, required none", instr);
        end else begin
          m_data = exp_data_q.pop_front();
          m_pc   = exp_pc_q.pop_front();
          chk("instr", instr, m_data);
          chk("pc", pc, m_pc);
          chk("opcode", {26'd0, opcode}, {26'd0, m_data[31:26]});
          chk("funct", {26'd0, funct}, {26'd0, m_data[5:0]});
          chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        end
      end
    end
    prev_req   = imem_req;
    prev_valid = instr_valid;
  end

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  sel;
    logic [31:0] jr;
    logic [31:0] nxt;   // hand-computed next fetch address
    logic [3:0]  ack_dly;
    logic [3:0]  rdy_dly;
    logic        hlt_fetch;
    logic        hlt_after;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] cur_addr;
    int t;
    vecs[0]  = '{32'h8C08_0004, 2'b00, 32'h0,         32'h0000_0004, 4'd1, 4'd0, 1'b0, 1'b0};
    vecs[1]  = '{32'h0000_0000, 2'b11, 32'h0000_0100, 32'h0000_0100, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[2]  = '{32'h1000_FFFE, 2'b01, 32'h0,         32'h0000_00FC, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[3]  = '{32'h1000_FFFE, 2'b11, 32'h0000_0100, 32'h0000_0100, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[4]  = '{32'h1000_FFFE, 2'b00, 32'h0,         32'h0000_0104, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[5]  = '{32'h0000_0000, 2'b11, 32'h1000_0010, 32'h1000_0010, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[6]  = '{32'h0C00_0040, 2'b10, 32'h0,         32'h1000_0100, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[7]  = '{32'h0000_0000, 2'b11, 32'h1000_0010, 32'h1000_0010, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[8]  = '{32'h0C00_0040, 2'b11, 32'h0000_2000, 32'h0000_2000, 4'd2, 4'd5, 1'b0, 1'b0};
    vecs[9]  = '{32'h1234_5678, 2'b11, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 4'd3, 4'd0, 1'b1, 1'b1};
    vecs[10] = '{32'h0000_0020, 2'b00, 32'h0,         32'h0000_0000, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[11] = '{32'h8C08_0004, 2'b11, 32'h0000_0203, 32'h0000_0200, 4'd0, 4'd0, 1'b0, 1'b0};

    // reset state
    @(negedge clock);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_fault", {31'd0, fault}, 32'd0);

    cur_addr = 32'h0;
    exp_addr_q.push_back(cur_addr);
    exp_data_q.push_back(vecs[0].data);
    exp_pc_q.push_back(cur_addr);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      t = 0;
      while (!imem_req && t < 50) begin @(negedge clock); t++; end
      if (!imem_req) chk("req_wait", 32'd0, 32'd1);
      if (vecs[i].hlt_fetch) halt = 1'b1;
      for (int d = 0; d < int'(vecs[i].ack_dly); d++) @(negedge clock);
      imem_ack = 1'b1;
      imem_rdata = vecs[i].data;
      @(negedge clock);
      imem_ack = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      t = 0;
      while (!instr_valid && t < 50) begin @(negedge clock); t++; end
      if (!instr_valid) chk("valid_wait", 32'd0, 32'd1);
      for (int d = 0; d < int'(vecs[i].rdy_dly); d++) begin
        chk("hold_instr", instr, vecs[i].data);
        chk("hold_pc", pc, cur_addr);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        @(negedge clock);
      end
      instr_ready = 1'b1;
      sel_pc = vecs[i].sel;
      jr_target = vecs[i].jr;
      halt = vecs[i].hlt_after;
      exp_addr_q.push_back(vecs[i].nxt);
      if (i + 1 < NV) begin
        exp_data_q.push_back(vecs[i + 1].data);
        exp_pc_q.push_back(vecs[i].nxt);
      end
      @(negedge clock);
      instr_ready = 1'b0;
      sel_pc = 2'b00;
      chk("valid_drop", {31'd0, instr_valid}, 32'd0);
      chk("next_pc", pc, vecs[i].nxt);
      if (vecs[i].hlt_after) begin
        for (int d = 0; d < 4; d++) begin
          chk("halt_no_req", {31'd0, imem_req}, 32'd0);
          @(negedge clock);
        end
        halt = 1'b0;
      end
      cur_addr = vecs[i].nxt;
    end

    // timeout at 0x200 with no ack
    t = 0;
    while (!imem_req && t < 50) begin @(negedge clock); t++; end
    t = 0;
    while (imem_req && t < 20) begin @(negedge clock); t++; end
    chk("timeout_req_cycles", t, 32'd4);
    chk("timeout_fault", {31'd0, fault}, 32'd1);
    chk("timeout_req_low", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    @(negedge clock);
    imem_ack = 1'b0;
    chk("late_ack_fault", {31'd0, fault}, 32'd1);
    chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("late_ack_req", {31'd0, imem_req}, 32'd0);
    chk("late_ack_instr", instr, 32'h8C08_0004);

    halt = 1'b1;
    #2 reset_n = 1'b0;
    @(negedge clock);
    chk("rst2_fault", {31'd0, fault}, 32'd0);
    chk("rst2_pc", pc, 32'h0);
    chk("rst2_instr", instr, 32'h0);
    reset_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      @(negedge clock);
      chk("halt_idle_req", {31'd0, imem_req}, 32'd0);
    end
    chk("sb_addr_empty", exp_addr_q.size(), 32'd0);
    chk("sb_instr_empty", exp_data_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
